// File: rtl/sar_converter_if.sv
// Handshake and DAC/comparator bundle for the successive-approximation converter.
// The converter uses the slave modport; the consumer/analog side uses master.
interface sar_converter_if;
  logic       soc;
  logic       eoc;
  logic [7:0] x;
  logic [7:0] dac;
  logic       cmp;

  modport master (
    output soc,
    output cmp,
    input  eoc,
    input  x,
    input  dac
  );

  modport slave (
    input  soc,
    input  cmp,
    output eoc,
    output x,
    output dac
  );
endinterface

// File: rtl/sar_converter.sv
// 8-bit successive-approximation controller with soc/eoc handshake.
// Define SAR_MAJORITY_EN for a 3-sample majority vote on cmp (dwell grows by 2).
module sar_converter #(
  parameter int unsigned SETTLE = 2
) (
  input logic           clock,
  input logic           reset_,
  sar_converter_if.slave bus
);

`ifdef SAR_MAJORITY_EN
  localparam int unsigned DWELL = SETTLE + 2;
`else
  localparam int unsigned DWELL = SETTLE;
`endif
  localparam logic [4:0] CntLoad = 5'(DWELL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAck   = 2'd1;
  localparam logic [1:0] StTrial = 2'd2;

  logic [1:0] state_q, state_d;
  logic       eoc_q, eoc_d;
  logic [7:0] x_q, x_d;
  logic [7:0] dac_q, dac_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] code;
  logic       decision;

`ifdef SAR_MAJORITY_EN
  // Two registered samples from the edges before the decision edge, plus the live one.
  logic [1:0] samp_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      samp_q <= '0;
    end else if (state_q == StTrial && cnt_q <= 5'd2) begin
      samp_q <= {samp_q[0], bus.cmp};
    end
  end

  assign decision = (samp_q[1] & samp_q[0]) | (samp_q[1] & bus.cmp) | (samp_q[0] & bus.cmp);
`else
  assign decision = bus.cmp;
`endif

  always_comb begin
    state_d = state_q;
    eoc_d   = eoc_q;
    x_d     = x_q;
    dac_d   = dac_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    code    = dac_q;
    case (state_q)
      StIdle: begin
        if (bus.soc) begin
          eoc_d   = 1'b0;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!bus.soc) begin
          dac_d   = 8'h80;
          idx_d   = 3'd7;
          cnt_d   = CntLoad;
          state_d = StTrial;
        end
      end
      StTrial: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          if (!decision) begin
            code[idx_q] = 1'b0;
          end
          if (idx_q != 3'd0) begin
            code[idx_q - 3'd1] = 1'b1;
            idx_d = idx_q - 3'd1;
            cnt_d = CntLoad;
            dac_d = code;
          end else begin
            x_d     = code;
            dac_d   = 8'h00;
            eoc_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        eoc_d   = 1'b1;
        dac_d   = 8'h00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= StIdle;
      eoc_q   <= 1'b1;
      x_q     <= 8'h00;
      dac_q   <= 8'h00;
      idx_q   <= 3'd7;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      eoc_q   <= eoc_d;
      x_q     <= x_d;
      dac_q   <= dac_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.eoc = eoc_q;
  assign bus.x   = x_q;
  assign bus.dac = dac_q;

endmodule

// File: tb/tb_sar_converter.sv
// Directed bench for sar_converter: two instances (SETTLE=1 and SETTLE=3) driven by
// an ideal comparator model cmp = (A >= dac), with an optional one-cycle glitch on dut1.
module tb_sar_converter;

`ifdef SAR_MAJORITY_EN
  localparam int D1 = 3;
  localparam int D2 = 5;
  localparam logic [7:0] GlitchExp = 8'h6C;
`else
  localparam int D1 = 1;
  localparam int D2 = 3;
  localparam logic [7:0] GlitchExp = 8'h80;
`endif

  logic       clock;
  logic       reset_;
  logic [7:0] a1, a2;
  logic       glitch1;
  int         total = 0;
  int         bad = 0;

  sar_converter_if bus1 ();
  sar_converter_if bus2 ();

  assign bus1.cmp = (a1 >= bus1.dac) ^ glitch1;
  assign bus2.cmp = (a2 >= bus2.dac);

  sar_converter #(.SETTLE(1)) dut1 (.clock(clock), .reset_(reset_), .bus(bus1));
  sar_converter #(.SETTLE(3)) dut2 (.clock(clock), .reset_(reset_), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_eoc(input int d);
    return (d == 1) ? bus1.eoc : bus2.eoc;
  endfunction

  function automatic logic [7:0] get_dac(input int d);
    return (d == 1) ? bus1.dac : bus2.dac;
  endfunction

  function automatic logic [7:0] get_x(input int d);
    return (d == 1) ? bus1.x : bus2.x;
  endfunction

  task automatic set_soc(input int d, input logic v);
    if (d == 1) bus1.soc = v;
    else        bus2.soc = v;
  endtask

  // Called #1 after a clock edge; soc is sampled on the next edge.
  task automatic convert(input int d, input logic [7:0] a, input bit glitch,
                         output int lat, output logic [7:0] x_o, output logic [63:0] seq);
    int dw;
    int cyc;
    dw  = (d == 1) ? D1 : D2;
    seq = '0;
    if (d == 1) a1 = a;
    else        a2 = a;
    set_soc(d, 1'b1);
    @(posedge clock); #1;
    check("ack_eoc", {31'b0, get_eoc(d)}, 32'd0);
    set_soc(d, 1'b0);
    @(posedge clock); #1;
    cyc = 0;
    seq[7:0] = get_dac(d);
    while (get_eoc(d) == 1'b0 && cyc < 200) begin
      glitch1 = glitch && (cyc == dw - 1);
      @(posedge clock); #1;
      glitch1 = 1'b0;
      cyc++;
      if (cyc % dw == 0 && cyc / dw < 8) seq[8*(cyc/dw) +: 8] = get_dac(d);
    end
    lat = cyc;
    x_o = get_x(d);
  endtask

  initial begin
    int          lat;
    logic [7:0]  xv;
    logic [63:0] seq;
    logic [63:0] exp_seq;
    bit          hold_ok;
    int          m;

    reset_  = 1'b0;
    bus1.soc = 1'b0;
    bus2.soc = 1'b0;
    a1 = 8'h00;
    a2 = 8'h00;
    glitch1 = 1'b0;
    #12;
    check("rst_eoc1", {31'b0, bus1.eoc}, 32'd1);
    check("rst_x1",   {24'b0, bus1.x},   32'h00);
    check("rst_dac1", {24'b0, bus1.dac}, 32'h00);
    check("rst_eoc2", {31'b0, bus2.eoc}, 32'd1);
    @(posedge clock); #1;
    reset_ = 1'b1;
    @(posedge clock); #1;

    // Main conversion, A=0xB3, with per-bit trial code sequence.
    convert(1, 8'hB3, 1'b0, lat, xv, seq);
    check("b3_x",   {24'b0, xv}, 32'hB3);
    check("b3_lat", lat, 8 * D1);
    exp_seq = {8'hB3, 8'hB2, 8'hB4, 8'hB8, 8'hB0, 8'hA0, 8'hC0, 8'h80};
    for (int k = 0; k < 8; k++) check($sformatf("b3_dac%0d", k), {24'b0, seq[8*k +: 8]},
                                      {24'b0, exp_seq[8*k +: 8]});
    check("b3_dac_end", {24'b0, bus1.dac}, 32'h00);

    // Boundaries on the SETTLE=3 instance.
    convert(2, 8'h00, 1'b0, lat, xv, seq);
    check("zero_x",   {24'b0, xv}, 32'h00);
    check("zero_lat", lat, 8 * D2);
    check("zero_dac", {24'b0, bus2.dac}, 32'h00);
    convert(2, 8'hFF, 1'b0, lat, xv, seq);
    check("ff_x",   {24'b0, xv}, 32'hFF);
    check("ff_lat", lat, 8 * D2);
    check("ff_dac", {24'b0, bus2.dac}, 32'h00);
    check("ff_x_stable", {24'b0, bus2.x}, 32'hFF);

    // soc held high for 50 cycles stays in ACK.
    a1 = 8'h3C;
    bus1.soc = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (bus1.eoc !== 1'b0 || bus1.dac !== 8'h00) hold_ok = 1'b0;
    end
    check("hold_ack", {31'b0, hold_ok}, 32'd1);
    bus1.soc = 1'b0;
    @(posedge clock); #1;
    check("hold_release_dac", {24'b0, bus1.dac}, 32'h80);
    lat = 0;
    while (bus1.eoc == 1'b0 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    check("hold_lat", lat, 8 * D1);
    check("hold_x", {24'b0, bus1.x}, 32'h3C);

    // Asynchronous reset during bit 4.
    a1 = 8'h5A;
    bus1.soc = 1'b1;
    @(posedge clock); #1;
    bus1.soc = 1'b0;
    @(posedge clock); #1;
    repeat (3 * D1) @(posedge clock);
    #1;
    check("mid_dac", {24'b0, bus1.dac}, 32'h50);
    #3;
    reset_ = 1'b0;
    #1;
    check("arst_eoc", {31'b0, bus1.eoc}, 32'd1);
    check("arst_x",   {24'b0, bus1.x},   32'h00);
    check("arst_dac", {24'b0, bus1.dac}, 32'h00);
    @(posedge clock); #1;
    reset_ = 1'b1;
    @(posedge clock); #1;
    convert(1, 8'h5A, 1'b0, lat, xv, seq);
    check("after_rst_x", {24'b0, xv}, 32'h5A);

    // One-cycle comparator glitch on the bit-7 decision edge.
    convert(1, 8'h6C, 1'b1, lat, xv, seq);
    check("glitch_x",   {24'b0, xv}, {24'b0, GlitchExp});
    check("glitch_lat", lat, 8 * D1);

    // Back-to-back with a 3/4 m + x/4 averaging consumer.
    m = 0;
    convert(1, 8'h40, 1'b0, lat, xv, seq);
    check("b2b_x40", {24'b0, xv}, 32'h40);
    m = (3 * m + int'(xv)) >> 2;
    convert(1, 8'hC0, 1'b0, lat, xv, seq);
    check("b2b_xc0", {24'b0, xv}, 32'hC0);
    m = (3 * m + int'(xv)) >> 2;
    check("avg_m", m, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
